// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan decoder.
// Holds the FSM state enum, mode encodings and the one-hot helper.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIRECT,
      ST_SCAN
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

   function automatic logic [MAX_OUT_W-1:0] onehot(
      input logic [MAX_SEL_W-1:0] i_idx
   );
      logic [MAX_OUT_W-1:0] v;
      v        = '0;
      v[i_idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational index to one-hot decoder.
// Ports: i_idx (line index), o_onehot (2**SEL_W one-hot lines).
module onehot_decode
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 4
) (
   input  logic [SEL_W-1:0]      i_idx,
   output logic [2**SEL_W-1:0]   o_onehot
);

   localparam int OUT_W = 2 ** SEL_W;

   logic [MAX_OUT_W-1:0] w_full;

   assign w_full   = onehot(MAX_SEL_W'(i_idx));
   assign o_onehot = w_full[OUT_W-1:0];

   // Upper lines of the shared helper are never used at this width.
   generate
      if (OUT_W < MAX_OUT_W) begin : g_unused
         logic w_unused;
         assign w_unused = ^w_full[MAX_OUT_W-1:OUT_W];
      end
   endgenerate

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with DIRECT (handshaked select) and SCAN modes.
// Ports: clk, rst_n, en, mode, sel_valid/sel/sel_ready, out, idx, wrap.
module scan_decoder
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned DWELL      = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   output logic                sel_ready,
   output logic [2**SEL_W-1:0] out,
   output logic [SEL_W-1:0]    idx,
   output logic                wrap
);

   localparam int OUT_W = 2 ** SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = '1;
   localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

   state_t           r_state;
   state_t           w_state_nx;
   logic [SEL_W-1:0] r_idx;
   logic [SEL_W-1:0] w_idx_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             r_wrap;
   logic             w_wrap_nx;
   logic [OUT_W-1:0] r_out;
   logic [OUT_W-1:0] w_onehot;
   logic [OUT_W-1:0] w_out_nx;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;

   assign w_last = (r_cnt == CNT_LAST);

   // Ready is withheld on a mode-change cycle so an accept is never dropped.
   always_comb begin
      w_ready = 1'b0;
      if (en) begin
         unique case (r_state)
            ST_DIRECT: w_ready = (mode == MODE_DIRECT);
            ST_SCAN:   w_ready = (mode == MODE_SCAN) & w_last;
            default:   w_ready = 1'b0;
         endcase
      end
   end

   assign w_accept = sel_valid & w_ready;

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_cnt_nx   = r_cnt;
      w_wrap_nx  = 1'b0;
      if (!en) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_state_nx = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
               w_cnt_nx   = '0;
            end
            ST_DIRECT: begin
               if (mode == MODE_SCAN) begin
                  w_state_nx = ST_SCAN;
                  w_cnt_nx   = '0;
               end else if (w_accept) begin
                  w_idx_nx = sel;
               end
            end
            ST_SCAN: begin
               if (mode == MODE_DIRECT) begin
                  w_state_nx = ST_DIRECT;
                  w_cnt_nx   = '0;
               end else if (w_last) begin
                  w_cnt_nx = '0;
                  if (w_accept) begin
                     w_idx_nx = sel;
                  end else begin
                     w_idx_nx  = r_idx + SEL_W'(1);
                     w_wrap_nx = (r_idx == IDX_LAST);
                  end
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end

   onehot_decode #(
      .SEL_W (SEL_W)
   ) u_dec (
      .i_idx    (w_idx_nx),
      .o_onehot (w_onehot)
   );

   // XOR with INACTIVE turns one-hot into one-cold when ACTIVE_LOW.
   assign w_out_nx = (w_state_nx == ST_IDLE) ? INACTIVE
                                             : (w_onehot ^ INACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_wrap  <= 1'b0;
         r_out   <= INACTIVE;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
         r_wrap  <= w_wrap_nx;
         r_out   <= w_out_nx;
      end
   end

   assign sel_ready = w_ready;
   assign out       = r_out;
   assign idx       = r_idx;
   assign wrap      = r_wrap;

endmodule
